// File: rtl/sketch_counter_updater_if.sv
// -----------------------------------------------------------------------------
// sketch_counter_updater_if
//   Update-request handshake into the sketch counter read-modify-write engine.
//   A request (in_addr, in_inc) transfers when in_valid & in_ready.
//   Ports (signals):
//     in_valid  master->slave  request valid
//     in_ready  slave->master  request accepted this cycle when high with in_valid
//     in_addr   master->slave  counter index, RAMAddWidth bits
//     in_inc    master->slave  increment, IncWidth bits
// -----------------------------------------------------------------------------
interface sketch_counter_updater_if #(
   parameter int RAMAddWidth = 2,
   parameter int IncWidth    = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [RAMAddWidth-1:0] in_addr;
   logic [IncWidth-1:0]    in_inc;

   modport master (output in_valid, output in_addr, output in_inc, input in_ready);
   modport slave  (input in_valid, input in_addr, input in_inc, output in_ready);
endinterface

// File: rtl/sketch_counter_updater.sv
// -----------------------------------------------------------------------------
// sketch_counter_updater
//   Read-modify-write engine in front of a dual-port counter RAM. Each accepted
//   update reads the counter on port A, adds the zero-extended increment two
//   cycles later and writes the result back on port B. One update per clock;
//   in-flight results are forwarded so repeated hits to one counter are exact.
//   A sweep zeroes every counter on init_start.
//   Optional feature: define COUNTER_SATURATE_EN to make counters saturate at
//   all-ones instead of wrapping.
// Ports:
//   clock          single clock (RAM clock_a/clock_b tied to it)
//   aclr_n         asynchronous reset, active-low
//   init_start     one-cycle pulse: zero all counters
//   init_busy      high from init_start acceptance until the sweep completes
//   req            update request handshake (slave side)
//   ram_address_a  port A read address      ram_rden_a  port A read enable
//   ram_q_a        port A data, valid 2 cycles after ram_rden_a
//   ram_address_b  port B write address     ram_data_b  port B write data
//   ram_wren_b     port B write enable
//   upd_valid      pulse: an update writeback was issued this cycle
//   upd_value      value written back by that update
// -----------------------------------------------------------------------------
module sketch_counter_updater #(
   parameter int DataWidth   = 32,
   parameter int DataDepth   = 4,
   parameter int RAMAddWidth = 2,
   parameter int IncWidth    = 8
) (
   input  logic                   clock,
   input  logic                   aclr_n,
   input  logic                   init_start,
   output logic                   init_busy,
   sketch_counter_updater_if.slave req,
   output logic [RAMAddWidth-1:0] ram_address_a,
   output logic                   ram_rden_a,
   input  logic [DataWidth-1:0]   ram_q_a,
   output logic [RAMAddWidth-1:0] ram_address_b,
   output logic [DataWidth-1:0]   ram_data_b,
   output logic                   ram_wren_b,
   output logic                   upd_valid,
   output logic [DataWidth-1:0]   upd_value
);

   localparam logic [RAMAddWidth-1:0] LastAddr = RAMAddWidth'(DataDepth - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWEEP} state_t;
   state_t state;

   logic                   s1_valid, s2_valid;
   logic [RAMAddWidth-1:0] s1_addr, s2_addr;
   logic [IncWidth-1:0]    s1_inc, s2_inc;
   logic                   wb1_valid, wb2_valid;
   logic [RAMAddWidth-1:0] wb1_addr, wb2_addr;
   logic [DataWidth-1:0]   wb1_value, wb2_value;
   logic [RAMAddWidth-1:0] sweep_addr;

   logic                   open_state, init_go, accept, pipe_empty;
   logic [DataWidth-1:0]   inc_ext, base, new_value;

   assign open_state    = (state == IDLE) || (state == RUN);
   assign init_go       = init_start && open_state;
   assign req.in_ready  = open_state && !init_start;
   assign accept        = req.in_valid && req.in_ready;
   assign pipe_empty    = !s1_valid && !s2_valid;

   // Port A address must be presented in the accept cycle so the RAM's
   // registered read returns data in T+2.
   assign ram_rden_a    = accept;
   assign ram_address_a = accept ? req.in_addr : '0;

   assign inc_ext = DataWidth'(s2_inc);

   // wb1 covers a read issued before the previous writeback landed; wb2 covers
   // a read that hit the RAM on the same edge as a write (old data returned).
   always_comb begin
      base = ram_q_a;
      if (wb1_valid && (wb1_addr == s2_addr))
         base = wb1_value;
      else if (wb2_valid && (wb2_addr == s2_addr))
         base = wb2_value;
`ifdef COUNTER_SATURATE_EN
      begin
         logic [DataWidth:0] sum_ext;
         sum_ext   = {1'b0, base} + {1'b0, inc_ext};
         new_value = sum_ext[DataWidth] ? '1 : sum_ext[DataWidth-1:0];
      end
`else
      new_value = base + inc_ext;
`endif
   end

   assign ram_wren_b    = s2_valid || (state == SWEEP);
   assign ram_address_b = (state == SWEEP) ? sweep_addr : (s2_valid ? s2_addr : '0);
   assign ram_data_b    = s2_valid ? new_value : '0;
   assign upd_valid     = s2_valid;
   assign upd_value     = ram_data_b;

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state      <= IDLE;
         init_busy  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_addr    <= '0;
         s1_inc     <= '0;
         s2_valid   <= 1'b0;
         s2_addr    <= '0;
         s2_inc     <= '0;
         wb1_valid  <= 1'b0;
         wb1_addr   <= '0;
         wb1_value  <= '0;
         wb2_valid  <= 1'b0;
         wb2_addr   <= '0;
         wb2_value  <= '0;
         sweep_addr <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_addr <= req.in_addr;
            s1_inc  <= req.in_inc;
         end
         s2_valid  <= s1_valid;
         s2_addr   <= s1_addr;
         s2_inc    <= s1_inc;
         wb1_valid <= s2_valid;
         wb1_addr  <= s2_addr;
         wb1_value <= new_value;
         wb2_valid <= wb1_valid;
         wb2_addr  <= wb1_addr;
         wb2_value <= wb1_value;

         unique case (state)
            IDLE: begin
               if (init_go) begin
                  state     <= DRAIN;
                  init_busy <= 1'b1;
               end else if (accept) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (init_go) begin
                  state     <= DRAIN;
                  init_busy <= 1'b1;
               end else if (!accept && pipe_empty) begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (pipe_empty) begin
                  state      <= SWEEP;
                  sweep_addr <= '0;
               end
            end
            SWEEP: begin
               sweep_addr <= sweep_addr + 1'b1;
               if (sweep_addr == LastAddr) begin
                  state     <= IDLE;
                  init_busy <= 1'b0;
                  wb1_valid <= 1'b0;
                  wb2_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sketch_counter_updater.sv
// -----------------------------------------------------------------------------
// tb_sketch_counter_updater
//   Directed bench for sketch_counter_updater with a behavioural dual-port RAM
//   (read on the edge after rden, one more output register, old data on a
//   same-edge read/write collision).
// -----------------------------------------------------------------------------
module tb_sketch_counter_updater;
   localparam int DW = 32;
   localparam int DD = 4;
   localparam int AW = 2;
   localparam int IW = 8;

   logic          clock = 1'b0;
   logic          aclr_n = 1'b0;
   logic          init_start = 1'b0;
   logic          init_busy;
   logic [AW-1:0] ram_address_a, ram_address_b;
   logic          ram_rden_a, ram_wren_b, upd_valid;
   logic [DW-1:0] ram_q_a, ram_data_b, upd_value;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clock = ~clock;

   sketch_counter_updater_if #(.RAMAddWidth(AW), .IncWidth(IW)) req ();

   sketch_counter_updater #(
      .DataWidth(DW), .DataDepth(DD), .RAMAddWidth(AW), .IncWidth(IW)
   ) dut (
      .clock(clock), .aclr_n(aclr_n), .init_start(init_start), .init_busy(init_busy),
      .req(req.slave),
      .ram_address_a(ram_address_a), .ram_rden_a(ram_rden_a), .ram_q_a(ram_q_a),
      .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
      .upd_valid(upd_valid), .upd_value(upd_value)
   );

   // RAM model with a preload port for the bench
   logic [DW-1:0] mem [DD];
   logic [DW-1:0] q1, q2;
   logic          preload_en = 1'b0;
   logic [AW-1:0] preload_addr = '0;
   logic [DW-1:0] preload_val = '0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!aclr_n) begin
         for (int i = 0; i < DD; i++) mem[i] <= 32'hA5A5_0000 | i;
      end else begin
         if (ram_rden_a) q1 <= mem[ram_address_a];
         q2 <= q1;
         if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
         if (preload_en) mem[preload_addr] <= preload_val;
      end
   end
   assign ram_q_a = q2;

   // writeback log, sampled mid-cycle
   logic [DW-1:0] log_val[$];
   logic [AW-1:0] log_addr[$];
   int            log_cyc[$];
   always @(negedge clock) begin
      if (aclr_n && upd_valid === 1'b1) begin
         log_val.push_back(upd_value);
         log_addr.push_back(ram_address_b);
         log_cyc.push_back(cyc);
      end
   end

   // all driving tasks start right after a falling edge
   task automatic issue(input logic [AW-1:0] a, input logic [IW-1:0] inc);
      req.in_valid = 1'b1;
      req.in_addr  = a;
      req.in_inc   = inc;
      #1;
      checks++;
      if (ram_rden_a !== 1'b1 || ram_address_a !== a || req.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_port_a: rden=%b addr=%0d ready=%b, expected rden=1 addr=%0d ready=1",
                  ram_rden_a, ram_address_a, req.in_ready, a);
      end
      @(negedge clock);
      req.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      aclr_n = 1'b0;
      req.in_valid = 1'b0;
      req.in_addr = '0;
      req.in_inc = '0;
      repeat (3) @(negedge clock);
      checks++;
      if ({init_busy, ram_wren_b, ram_rden_a, upd_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/wren/rden/upd=%b expected 0000",
                  {init_busy, ram_wren_b, ram_rden_a, upd_valid});
      end
      checks++;
      if (ram_data_b !== '0 || ram_address_b !== '0 || ram_address_a !== '0) begin
         errors++;
         $display("FAIL reset_bus: data_b=%h addr_b=%0d addr_a=%0d expected 0", ram_data_b,
                  ram_address_b, ram_address_a);
      end
      checks++;
      if (req.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", req.in_ready);
      end
      aclr_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_init_sweep;
      int busy_n = 0;
      int nw = 0;
      int upd_n = 0;
      init_start = 1'b1;
      @(negedge clock);
      init_start = 1'b0;
      for (int i = 0; i < 20 && init_busy === 1'b1; i++) begin
         busy_n++;
         if (ram_wren_b === 1'b1) begin
            checks++;
            if (ram_address_b !== AW'(nw) || ram_data_b !== '0) begin
               errors++;
               $display("FAIL sweep_write: addr=%0d data=%h expected addr=%0d data=0",
                        ram_address_b, ram_data_b, nw);
            end
            nw++;
         end
         if (upd_valid === 1'b1) upd_n++;
         @(negedge clock);
      end
      checks++;
      if (init_busy !== 1'b0 || busy_n != DD + 1) begin
         errors++;
         $display("FAIL sweep_busy: busy=%b high_cycles=%0d expected busy=0 high_cycles=%0d",
                  init_busy, busy_n, DD + 1);
      end
      checks++;
      if (nw != DD || upd_n != 0) begin
         errors++;
         $display("FAIL sweep_count: writes=%0d upd=%0d expected writes=%0d upd=0", nw, upd_n, DD);
      end
      for (int i = 0; i < DD; i++) begin
         checks++;
         if (mem[i] !== '0) begin
            errors++;
            $display("FAIL sweep_mem%0d: got %h expected 0", i, mem[i]);
         end
      end
   endtask

   task automatic test_updates;
      logic [DW-1:0] ev[2] = '{32'd5, 32'd7};
      logic [AW-1:0] ea[2] = '{2'd1, 2'd2};
      int b = log_val.size();
      int t0 = cyc;
      issue(2'd1, 8'd5);
      issue(2'd2, 8'd7);
      repeat (4) @(negedge clock);
      checks++;
      if (log_val.size() != b + 2) begin
         errors++;
         $display("FAIL upd_count: got %0d expected 2", log_val.size() - b);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_val[b+i] !== ev[i] || log_addr[b+i] !== ea[i] || log_cyc[b+i] != t0 + 2 + i) begin
               errors++;
               $display("FAIL upd_%0d: val=%h addr=%0d cyc=%0d expected val=%h addr=%0d cyc=%0d", i,
                        log_val[b+i], log_addr[b+i], log_cyc[b+i], ev[i], ea[i], t0 + 2 + i);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int b = log_val.size();
      int t0 = cyc;
      repeat (4) issue(2'd3, 8'd1);
      repeat (4) @(negedge clock);
      checks++;
      if (log_val.size() != b + 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 4", log_val.size() - b);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_val[b+i] !== DW'(i + 1) || log_cyc[b+i] != t0 + 2 + i) begin
               errors++;
               $display("FAIL b2b_%0d: val=%h cyc=%0d expected val=%h cyc=%0d", i,
                        log_val[b+i], log_cyc[b+i], i + 1, t0 + 2 + i);
            end
         end
      end
   endtask

   task automatic test_wb2_collision;
      // A=0 (was 0), B=1 (holds 5 from test_updates)
      logic [DW-1:0] ev[3] = '{32'd2, 32'd7, 32'd4};
      int b = log_val.size();
      issue(2'd0, 8'd2);
      issue(2'd1, 8'd2);
      issue(2'd0, 8'd2);
      repeat (4) @(negedge clock);
      checks++;
      if (log_val.size() != b + 3) begin
         errors++;
         $display("FAIL aba_count: got %0d expected 3", log_val.size() - b);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_val[b+i] !== ev[i]) begin
               errors++;
               $display("FAIL aba_%0d: got %h expected %h", i, log_val[b+i], ev[i]);
            end
         end
      end
   endtask

   task automatic test_saturate;
`ifdef COUNTER_SATURATE_EN
      logic [DW-1:0] ev[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
      logic [DW-1:0] ev[2] = '{32'h0000_0001, 32'h0000_0004};
`endif
      int b;
      preload_addr = 2'd2;
      preload_val  = 32'hFFFF_FFFE;
      preload_en   = 1'b1;
      @(negedge clock);
      preload_en = 1'b0;
      b = log_val.size();
      issue(2'd2, 8'd3);
      issue(2'd2, 8'd3);
      repeat (4) @(negedge clock);
      checks++;
      if (log_val.size() != b + 2) begin
         errors++;
         $display("FAIL sat_count: got %0d expected 2", log_val.size() - b);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_val[b+i] !== ev[i]) begin
               errors++;
               $display("FAIL sat_%0d: got %h expected %h", i, log_val[b+i], ev[i]);
            end
         end
      end
   endtask

   task automatic test_init_collision;
      // addr0 holds 4, addr1 holds 7; both updates must land before the sweep
      logic [DW-1:0] ev[3] = '{32'd5, 32'd8, 32'd9};
      logic [AW-1:0] ea[3] = '{2'd0, 2'd1, 2'd2};
      int ec[3];
      int b = log_val.size();
      int t0 = cyc;
      int t_acc;
      bit ready_leak = 1'b0;
      bit done = 1'b0;
      issue(2'd0, 8'd1);
      issue(2'd1, 8'd1);
      init_start   = 1'b1;
      req.in_valid = 1'b1;
      req.in_addr  = 2'd2;
      req.in_inc   = 8'd9;
      #1;
      checks++;
      if (req.in_ready !== 1'b0 || ram_rden_a !== 1'b0) begin
         errors++;
         $display("FAIL coll_ready: ready=%b rden=%b expected 0 0", req.in_ready, ram_rden_a);
      end
      @(negedge clock);
      init_start = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (init_busy === 1'b1) begin
            if (req.in_ready !== 1'b0) ready_leak = 1'b1;
            @(negedge clock);
         end else begin
            done = 1'b1;
         end
      end
      checks++;
      if (!done || ready_leak || req.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL coll_busy: done=%b ready_leak=%b ready=%b expected 1 0 1", done,
                  ready_leak, req.in_ready);
      end
      t_acc = cyc;
      @(negedge clock);
      req.in_valid = 1'b0;
      repeat (4) @(negedge clock);
      ec = '{t0 + 2, t0 + 3, t_acc + 2};
      checks++;
      if (log_val.size() != b + 3) begin
         errors++;
         $display("FAIL coll_count: got %0d expected 3", log_val.size() - b);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_val[b+i] !== ev[i] || log_addr[b+i] !== ea[i] || log_cyc[b+i] != ec[i]) begin
               errors++;
               $display("FAIL coll_%0d: val=%h addr=%0d cyc=%0d expected val=%h addr=%0d cyc=%0d", i,
                        log_val[b+i], log_addr[b+i], log_cyc[b+i], ev[i], ea[i], ec[i]);
            end
         end
      end
      checks++;
      if (mem[0] !== '0 || mem[1] !== '0 || mem[2] !== 32'd9) begin
         errors++;
         $display("FAIL coll_mem: mem0=%h mem1=%h mem2=%h expected 0 0 9", mem[0], mem[1], mem[2]);
      end
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_updates();
      test_back_to_back();
      test_wb2_collision();
      test_saturate();
      test_init_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
